// File: rtl/wave_pkg.sv
// -----------------------------------------------------------------------------
// wave_pkg
// Shared definitions for the custom-waveform upload path: sequencer state
// encoding, command opcodes, ctrl-byte bit positions, sticky error codes and
// the sample offset that converts an unsigned 14-bit code to a signed sample.
// -----------------------------------------------------------------------------
package wave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LO,
        ST_HI,
        ST_TAIL,
        ST_COMMIT,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] CMD_CUSTOM_WAVE = 8'hFC;
    localparam logic [7:0] CMD_DAC         = 8'hFD;

    // ctrl byte bit positions
    localparam int CTRL_AUTO_BIT    = 2;
    localparam int CTRL_ONESHOT_BIT = 1;

    // header is ctrl, count_hi, count_lo, rate[31:24..7:0]
    localparam logic [2:0] HDR_LAST_IDX = 3'd6;

    // sticky error codes
    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_BAD_COUNT = 2'd1;
    localparam logic [1:0] ERR_SHORT     = 2'd2;
    localparam logic [1:0] ERR_ABORT     = 2'd3;

    // unsigned code minus this gives the signed DAC sample
    localparam logic [13:0] SAMPLE_OFFSET = 14'd8192;

endpackage

// File: rtl/wave_upload_sequencer_pack.sv
// -----------------------------------------------------------------------------
// wave_sample_pack
// Assembles a lo/hi payload byte pair into a signed 14-bit sample and issues a
// one-cycle waveform RAM write the cycle after the hi byte arrives. The write
// address restarts at 0 on i_clear and advances by one per sample.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   i_clear      restart the write address at 0 (new frame)
//   i_lo_valid   i_data is a sample lo byte
//   i_hi_valid   i_data is a sample hi byte (bits 7:6 ignored)
//   i_data       payload byte
//   o_we         RAM write strobe
//   o_waddr      RAM write address
//   o_wdata      signed 14-bit sample
// -----------------------------------------------------------------------------
module wave_sample_pack
    import wave_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_lo_valid,
    input  logic              i_hi_valid,
    input  logic [7:0]        i_data,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [13:0]       o_wdata
);

    logic [7:0]        r_lo;
    logic [ADDR_W-1:0] r_next_addr;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [13:0]       r_wdata;
    logic [13:0]       w_offset;

    assign w_offset = {i_data[5:0], r_lo};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo        <= '0;
            r_next_addr <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            r_we <= 1'b0;
            if (i_clear) begin
                r_next_addr <= '0;
            end
            if (i_lo_valid) begin
                r_lo <= i_data;
            end
            if (i_hi_valid) begin
                r_we        <= 1'b1;
                r_waddr     <= r_next_addr;
                r_next_addr <= r_next_addr + 1'b1;
                // modulo-2^14 subtraction: same as inverting bit 13
                r_wdata     <= w_offset - SAMPLE_OFFSET;
            end
        end
    end

    assign o_we    = r_we;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/wave_upload_sequencer.sv
// -----------------------------------------------------------------------------
// wave_upload_sequencer
// Consumes a custom-waveform (0xFC) payload: decodes the 7-byte header into
// shadow registers, streams lo/hi sample pairs into the waveform RAM and
// commits the playback configuration only after a good-checksum frame end.
// Also hands DAC ownership back to the DDS path on dds_cmd.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_start/data/valid          payload stream from the frame parser
//   cmd_done / cmd_abort          frame end, checksum good / bad
//   dds_cmd                       DAC (0xFD) command accepted
//   ram_we/waddr/wdata            waveform RAM write port
//   cfg_count/rate/oneshot        committed playback configuration
//   play_start, play_en           playback engine restart pulse / enable
//   custom_active                 DAC mux select (1 = custom waveform)
//   busy                          upload in progress
//   err                           sticky status of the last frame
// -----------------------------------------------------------------------------
module wave_upload_sequencer
    import wave_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int MAX_SAMPLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic [7:0]        cmd_data,
    input  logic              cmd_valid,
    input  logic              cmd_done,
    input  logic              cmd_abort,
    input  logic              dds_cmd,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [13:0]       ram_wdata,
    output logic [ADDR_W:0]   cfg_count,
    output logic [31:0]       cfg_rate,
    output logic              cfg_oneshot,
    output logic              play_start,
    output logic              play_en,
    output logic              custom_active,
    output logic              busy,
    output logic [1:0]        err
);

    state_t          r_state, w_next_state;
    logic [2:0]      r_hdr_idx;
    logic            r_sh_auto, r_sh_oneshot;
    logic [15:0]     r_sh_count;
    logic [31:0]     r_sh_rate;
    logic [ADDR_W:0] r_remaining;
    logic [ADDR_W:0] r_cfg_count;
    logic [31:0]     r_cfg_rate;
    logic            r_cfg_oneshot, r_play_start, r_play_en, r_custom;
    logic [1:0]      r_err;

    logic            w_enter_hdr, w_hdr_byte, w_lo_byte, w_hi_byte;
    logic            w_err_load, w_count_ok, w_commit, w_last_sample;
    logic [1:0]      w_err_val;

    assign w_count_ok    = (r_sh_count != 16'd0) && (32'(r_sh_count) <= MAX_SAMPLES);
    assign w_commit      = (r_state == ST_COMMIT);
    assign w_last_sample = (r_remaining == {{ADDR_W{1'b0}}, 1'b1});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Priority: abort > done > start > valid.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = (r_state == ST_COMMIT) ? ST_IDLE : r_state;
        w_enter_hdr  = 1'b0;
        w_hdr_byte   = 1'b0;
        w_lo_byte    = 1'b0;
        w_hi_byte    = 1'b0;
        w_err_load   = 1'b0;
        w_err_val    = ERR_OK;
        if (cmd_abort && r_state != ST_IDLE) begin
            w_next_state = ST_IDLE;
            w_err_load   = 1'b1;
            w_err_val    = ERR_ABORT;
        end else if (cmd_done && r_state != ST_IDLE) begin
            case (r_state)
                ST_HDR, ST_LO, ST_HI: begin
                    w_next_state = ST_IDLE;
                    w_err_load   = 1'b1;
                    w_err_val    = ERR_SHORT;
                end
                ST_TAIL:  w_next_state = ST_COMMIT;
                ST_DRAIN: w_next_state = ST_IDLE;
                default:  ;
            endcase
        end else if (cmd_start) begin
            w_next_state = ST_HDR;
            w_enter_hdr  = 1'b1;
        end else if (cmd_valid) begin
            case (r_state)
                ST_HDR: begin
                    w_hdr_byte = 1'b1;
                    if (r_hdr_idx == HDR_LAST_IDX) begin
                        // count bytes are already in the shadow by byte 6
                        if (w_count_ok) begin
                            w_next_state = ST_LO;
                        end else begin
                            w_next_state = ST_DRAIN;
                            w_err_load   = 1'b1;
                            w_err_val    = ERR_BAD_COUNT;
                        end
                    end
                end
                ST_LO: begin
                    w_lo_byte    = 1'b1;
                    w_next_state = ST_HI;
                end
                ST_HI: begin
                    w_hi_byte    = 1'b1;
                    w_next_state = w_last_sample ? ST_TAIL : ST_LO;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr_idx     <= '0;
            r_sh_auto     <= 1'b0;
            r_sh_oneshot  <= 1'b0;
            r_sh_count    <= '0;
            r_sh_rate     <= '0;
            r_remaining   <= '0;
            r_cfg_count   <= '0;
            r_cfg_rate    <= '0;
            r_cfg_oneshot <= 1'b0;
            r_play_start  <= 1'b0;
            r_play_en     <= 1'b0;
            r_custom      <= 1'b0;
            r_err         <= ERR_OK;
        end else begin
            r_play_start <= 1'b0;
            if (w_commit) begin
                r_cfg_count   <= r_sh_count[ADDR_W:0];
                r_cfg_rate    <= r_sh_rate;
                r_cfg_oneshot <= r_sh_oneshot;
                if (r_sh_auto) begin
                    r_play_start <= 1'b1;
                    r_play_en    <= 1'b1;
                    r_custom     <= 1'b1;
                end
            end
            if (w_enter_hdr) begin
                r_hdr_idx    <= '0;
                r_sh_auto    <= 1'b0;
                r_sh_oneshot <= 1'b0;
                r_sh_count   <= '0;
                r_sh_rate    <= '0;
                r_err        <= ERR_OK;
                r_play_en    <= 1'b0;
            end
            if (w_hdr_byte) begin
                r_hdr_idx <= r_hdr_idx + 3'd1;
                case (r_hdr_idx)
                    3'd0: begin
                        r_sh_auto    <= cmd_data[CTRL_AUTO_BIT];
                        r_sh_oneshot <= cmd_data[CTRL_ONESHOT_BIT];
                    end
                    3'd1, 3'd2: r_sh_count <= {r_sh_count[7:0], cmd_data};
                    default:    r_sh_rate  <= {r_sh_rate[23:0], cmd_data};
                endcase
                if (r_hdr_idx == HDR_LAST_IDX) begin
                    r_remaining <= r_sh_count[ADDR_W:0];
                end
            end
            if (w_hi_byte) begin
                r_remaining <= r_remaining - 1'b1;
            end
            if (w_err_load) begin
                r_err <= w_err_val;
            end
            // DDS takeover wins over a coincident commit
            if (dds_cmd) begin
                r_play_start <= 1'b0;
                r_play_en    <= 1'b0;
                r_custom     <= 1'b0;
            end
        end
    end

    wave_sample_pack #(
        .ADDR_W (ADDR_W)
    ) u_pack (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_enter_hdr),
        .i_lo_valid (w_lo_byte),
        .i_hi_valid (w_hi_byte),
        .i_data     (cmd_data),
        .o_we       (ram_we),
        .o_waddr    (ram_waddr),
        .o_wdata    (ram_wdata)
    );

    assign cfg_count     = r_cfg_count;
    assign cfg_rate      = r_cfg_rate;
    assign cfg_oneshot   = r_cfg_oneshot;
    assign play_start    = r_play_start;
    assign play_en       = r_play_en;
    assign custom_active = r_custom;
    assign busy          = (r_state != ST_IDLE);
    assign err           = r_err;

endmodule

// File: tb/tb_wave_upload_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wave_upload_sequencer
// Scoreboard bench: the stimulus side applies the frame rules to a small
// model and queues the RAM writes and play_start events it expects; a monitor
// pops and compares whenever the DUT presents ram_we or play_start.
// -----------------------------------------------------------------------------
module tb_wave_upload_sequencer;

    localparam int ADDR_W      = 12;
    localparam int MAX_SAMPLES = 4096;
    localparam int END_DONE    = 0;
    localparam int END_ABORT   = 1;
    localparam int END_NONE    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_start = 1'b0, cmd_valid = 1'b0, cmd_done = 1'b0;
    logic              cmd_abort = 1'b0, dds_cmd = 1'b0;
    logic [7:0]        cmd_data = 8'h00;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [13:0]       ram_wdata;
    logic [ADDR_W:0]   cfg_count;
    logic [31:0]       cfg_rate;
    logic              cfg_oneshot, play_start, play_en, custom_active, busy;
    logic [1:0]        err;

    wave_upload_sequencer #(.ADDR_W(ADDR_W), .MAX_SAMPLES(MAX_SAMPLES)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_data(cmd_data),
        .cmd_valid(cmd_valid), .cmd_done(cmd_done), .cmd_abort(cmd_abort),
        .dds_cmd(dds_cmd), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .cfg_count(cfg_count), .cfg_rate(cfg_rate),
        .cfg_oneshot(cfg_oneshot), .play_start(play_start), .play_en(play_en),
        .custom_active(custom_active), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int count; logic [31:0] rate; logic oneshot; } cfg_t;
    wr_t  wr_q[$];
    cfg_t ps_q[$];
    int   smp_q[$];

    int total = 0;
    int bad   = 0;

    // reference model of the externally visible state
    int          m_count;
    logic [31:0] m_rate;
    logic        m_oneshot, m_play_en, m_custom;
    int          m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 1)) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    task automatic model_reset();
        m_count = 0; m_rate = '0; m_oneshot = 1'b0;
        m_play_en = 1'b0; m_custom = 1'b0; m_err = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".err"},           32'(err),           32'(m_err));
        check({tag, ".cfg_count"},     32'(cfg_count),     32'(m_count));
        check({tag, ".cfg_rate"},      cfg_rate,           m_rate);
        check({tag, ".cfg_oneshot"},   32'(cfg_oneshot),   32'(m_oneshot));
        check({tag, ".play_en"},       32'(play_en),       32'(m_play_en));
        check({tag, ".custom_active"}, 32'(custom_active), 32'(m_custom));
        check({tag, ".busy"},          32'(busy),          32'd0);
        check({tag, ".play_start"},    32'(play_start),    32'd0);
    endtask

    task automatic fill_random(input int n);
        smp_q.delete();
        for (int i = 0; i < n; i++) smp_q.push_back(int'($urandom_range(0, 16383)));
    endtask

    // One frame. For a legal count, n_send samples are taken from smp_q; for an
    // illegal count, n_send garbage bytes follow the header.
    task automatic send_frame(input string tag, input logic [7:0] ctrl, input int count,
                              input logic [31:0] rate, input int n_send,
                              input int ending, input bit dds_mid);
        bit          ok;
        logic [15:0] c16;
        ok  = (count >= 1) && (count <= MAX_SAMPLES);
        c16 = count[15:0];

        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        m_err = 0;
        m_play_en = 1'b0;
        check({tag, ".busy_hi"}, 32'(busy), 32'd1);

        send_byte(ctrl);       gap();
        send_byte(c16[15:8]);  gap();
        send_byte(c16[7:0]);   gap();
        send_byte(rate[31:24]); gap();
        send_byte(rate[23:16]); gap();
        send_byte(rate[15:8]);  gap();
        send_byte(rate[7:0]);   gap();
        if (!ok) m_err = 1;

        if (dds_mid) begin
            dds_cmd = 1'b1;
            tick();
            dds_cmd = 1'b0;
            m_custom = 1'b0;
            m_play_en = 1'b0;
        end

        if (ok) begin
            for (int i = 0; i < n_send; i++) begin
                logic [13:0] off;
                logic [1:0]  junk;
                int          sv;
                wr_t         w;
                off  = smp_q[i][13:0];
                junk = 2'($urandom);
                send_byte(off[7:0]); gap();
                send_byte({junk, off[13:8]});
                sv     = int'(off) - 8192;
                w.addr = i;
                w.data = sv & 16'h3FFF;
                wr_q.push_back(w);
                gap();
            end
            if (n_send == count) begin
                repeat ($urandom_range(0, 2)) send_byte(8'($urandom));
            end
        end else begin
            for (int i = 0; i < n_send; i++) send_byte(8'($urandom));
        end

        if (ending == END_NONE) return;

        if (ending == END_ABORT) begin
            cmd_abort = 1'b1;
            m_err = 3;
        end else begin
            cmd_done = 1'b1;
            if (!ok) begin
                m_err = 1;
            end else if (n_send < count) begin
                m_err = 2;
            end else begin
                m_err = 0;
                m_count = count;
                m_rate = rate;
                m_oneshot = ctrl[1];
                if (ctrl[2]) begin
                    cfg_t c;
                    c.count = count; c.rate = rate; c.oneshot = ctrl[1];
                    ps_q.push_back(c);
                    m_play_en = 1'b1;
                    m_custom = 1'b1;
                end
            end
        end
        tick();
        cmd_abort = 1'b0;
        cmd_done  = 1'b0;
        tick();
        tick();
        check_state(tag);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                if (wr_q.size() == 0) begin
                    check("ram_we_unexpected", 32'(ram_we), 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("ram_waddr", 32'(ram_waddr), 32'(w.addr));
                    check("ram_wdata", 32'(ram_wdata), 32'(w.data));
                end
            end
            if (play_start) begin
                if (ps_q.size() == 0) begin
                    check("play_start_unexpected", 32'(play_start), 32'd0);
                end else begin
                    cfg_t c;
                    c = ps_q.pop_front();
                    check("ps.cfg_count",   32'(cfg_count),     32'(c.count));
                    check("ps.cfg_rate",    cfg_rate,           c.rate);
                    check("ps.cfg_oneshot", 32'(cfg_oneshot),   32'(c.oneshot));
                    check("ps.play_en",     32'(play_en),       32'd1);
                    check("ps.custom",      32'(custom_active), 32'd1);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("rst.ram_we",    32'(ram_we),    32'd0);
        check("rst.ram_waddr", 32'(ram_waddr), 32'd0);
        check("rst.ram_wdata", 32'(ram_wdata), 32'd0);
        check_state("rst");

        // good upload with auto-start
        smp_q = '{0, 8192, 16383, 4096};
        send_frame("good", 8'h04, 4, 32'h0000_1000, 4, END_DONE, 1'b0);

        // DDS takes the DAC back during playback
        dds_cmd = 1'b1;
        tick();
        dds_cmd = 1'b0;
        m_custom = 1'b0;
        m_play_en = 1'b0;
        check("dds.custom_active", 32'(custom_active), 32'd0);
        check("dds.play_en",       32'(play_en),       32'd0);

        // commit without auto-start
        fill_random(2);
        send_frame("noauto", 8'h00, 2, 32'h1234_5678, 2, END_DONE, 1'b0);

        // zero count, then an oversize count
        send_frame("zero", 8'h04, 0, 32'hDEAD_BEEF, 3, END_DONE, 1'b0);
        send_frame("over", 8'h04, MAX_SAMPLES + 1, 32'hDEAD_BEEF, 2, END_DONE, 1'b0);

        // short payload
        fill_random(2);
        send_frame("short", 8'h04, 3, 32'hCAFE_0001, 2, END_DONE, 1'b0);

        // checksum abort after a complete payload
        fill_random(4);
        send_frame("abort", 8'h04, 4, 32'hABCD_0000, 4, END_ABORT, 1'b0);

        // restart mid-data; the second frame commits
        fill_random(2);
        send_frame("restart_a", 8'h04, 5, 32'h1111_1111, 2, END_NONE, 1'b0);
        fill_random(3);
        send_frame("restart_b", 8'h06, 3, 32'h2222_2222, 3, END_DONE, 1'b0);

        // DDS command in the middle of an upload; upload still completes
        fill_random(3);
        send_frame("dds_mid", 8'h04, 3, 32'h3333_0003, 3, END_DONE, 1'b1);

        // randomized frames
        for (int f = 0; f < 14; f++) begin
            int   sel, cnt, ns, en;
            sel = $urandom_range(0, 9);
            if (sel == 0)      cnt = 0;
            else if (sel == 1) cnt = $urandom_range(MAX_SAMPLES + 1, 65535);
            else               cnt = $urandom_range(1, 8);
            if (cnt >= 1 && cnt <= MAX_SAMPLES)
                ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt - 1)) : cnt;
            else
                ns = $urandom_range(0, 4);
            en = ($urandom_range(0, 3) == 0) ? END_ABORT : END_DONE;
            fill_random(ns);
            send_frame($sformatf("rnd%0d", f), 8'($urandom), cnt, $urandom, ns, en,
                       1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of an upload
        fill_random(2);
        send_frame("rst_mid", 8'h04, 6, 32'h4444_4444, 2, END_NONE, 1'b0);
        tick();
        rst = 1'b1;
        #2;
        model_reset();
        check("rstmid.ram_we",    32'(ram_we),    32'd0);
        check("rstmid.ram_waddr", 32'(ram_waddr), 32'd0);
        check("rstmid.ram_wdata", 32'(ram_wdata), 32'd0);
        check_state("rstmid");
        tick();
        rst = 1'b0;
        tick();

        fill_random(2);
        send_frame("post_rst", 8'h06, 2, 32'h5555_0002, 2, END_DONE, 1'b0);

        repeat (3) tick();
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("ps_q_drained", 32'(ps_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_upload_sequencer.md
# wave_upload_sequencer

Controller between the command dispatcher and the custom-waveform playback datapath. It consumes the payload of a custom-waveform command (0xFC), decodes the header and writes the samples into the waveform RAM. It commits the playback configuration only when the frame checksum passes, and arbitrates DAC ownership between custom playback and the DDS handler. It sits inside `cdc`, between the frame parser and the playback engine / DAC output mux.

## Interface

**Parameters**
- `ADDR_W`, 12: waveform RAM address width.
- `MAX_SAMPLES`, 4096: largest legal sample count; must be ≤ 2^ADDR_W.

**Ports**
- `clk`  in  1  system clock (60 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_start`  in  1  pulse: parser accepted an 0xFC header.
- `cmd_data`  in  8  payload byte.
- `cmd_valid`  in  1  `cmd_data` valid for one cycle.
- `cmd_done`  in  1  pulse: frame ended, checksum good.
- `cmd_abort`  in  1  pulse: frame ended, checksum bad.
- `dds_cmd`  in  1  pulse: a DAC (0xFD) command was accepted.
- `ram_we`  out  1  waveform RAM write strobe.
- `ram_waddr`  out  ADDR_W  write address.
- `ram_wdata`  out  14  signed sample.
- `cfg_count`  out  ADDR_W+1  committed sample count.
- `cfg_rate`  out  32  committed phase-increment word.
- `cfg_oneshot`  out  1  committed one-shot flag.
- `play_start`  out  1  one-cycle playback restart pulse.
- `play_en`  out  1  playback engine enable.
- `custom_active`  out  1  DAC mux select (1 = custom waveform).
- `busy`  out  1  upload in progress.
- `err`  out  2  sticky status: 0 ok, 1 bad count, 2 short payload, 3 checksum abort.

## Operation

- **Payload layout:** ctrl, count_hi, count_lo, rate[31:24..7:0], then per sample lo byte and hi byte.
- **ctrl bits:** bit2 = auto-start, bit1 = one-shot (0 = loop). Other bits are ignored.
- **Sample decode:** offset = {hi[5:0], lo}; hi[7:6] ignored. `ram_wdata` = offset − 8192, which equals the offset with bit 13 inverted.
- **States:**
  - IDLE → HDR on `cmd_start`.
  - HDR takes 7 bytes. After the 7th byte, go to LO if count ∈ [1, MAX_SAMPLES]; otherwise set `err` = 1 and go to DRAIN.
  - LO → HI → LO alternates per sample. After the last HI byte, go to TAIL.
  - TAIL ignores extra bytes. On `cmd_done` go to COMMIT.
  - COMMIT lasts one cycle, then IDLE.
  - DRAIN ignores bytes until `cmd_done`/`cmd_abort`, then IDLE.
  - `cmd_done` in LO/HI/HDR sets `err` = 2 and goes to IDLE.
  - `cmd_abort` in any non-IDLE state sets `err` = 3 and goes to IDLE.
- **Entering HDR:** `play_en` drops to 0 and `err` clears to 0. `custom_active` is unchanged. Header fields go into shadow registers; `cfg_*` are not touched until COMMIT.
- **COMMIT:**
  - Copy shadow values to `cfg_*`.
  - If auto-start: `play_start` = 1, `play_en` = 1, `custom_active` = 1.
  - Otherwise `play_en` stays 0.
- **`dds_cmd`:** `custom_active` and `play_en` go to 0 the next cycle, in any state. The upload continues.
- **`cmd_start` while busy:** restart at HDR, discarding partial shadow data. Already-written RAM contents are not restored.
- **Priority on a coincident cycle:** `cmd_abort` > `cmd_done` > `cmd_start` > `cmd_valid`.
- **Failed or short upload:** `cfg_*` retain the previous committed values. `play_en` remains 0.

## Timing

- **Reset values:** all outputs 0; state IDLE; `cfg_count` = 0; `cfg_rate` = 0.
- **RAM writes:** `ram_we` asserts for one cycle, the cycle after the HI byte's `cmd_valid`. `ram_waddr` starts at 0 and increments per sample. The address never wraps because count ≤ MAX_SAMPLES.
- **Byte rate:** bytes may arrive back-to-back, one per cycle, with no stall output.
- **COMMIT:** is the cycle after `cmd_done`. `play_start`, `play_en` and `cfg_*` update at the end of that cycle and are visible 2 cycles after `cmd_done`.
- **`busy`:** high from the cycle after `cmd_start` until IDLE is re-entered.
- **Reset mid-upload:** immediate return to reset values. No further RAM writes.

## Structure

- **Shared package `wave_pkg`:** state enum, `CMD_CUSTOM_WAVE` = 8'hFC, `CMD_DAC` = 8'hFD, ctrl bit indices, error code constants, sample offset constant 8192.
- **Sub-module:** `wave_sample_pack`, which assembles a lo/hi byte pair into a signed 14-bit sample and drives the write strobe.

## Test plan

- **Good upload:** 4 samples {0, 8192, 16383, 4096}, ctrl 0x04, rate 0x0000_1000, `cmd_done`.
  - RAM addresses 0–3 receive −8192, 0, 8191, −4096.
  - `cfg_count` = 4.
  - `play_start` is one pulse; `custom_active` = 1.
- **Zero count:** count = 0 → `err` = 1; no `ram_we`; `cfg_*` unchanged; `play_en` = 0.
- **Short payload:** header declares 3 samples, 2 samples sent, then `cmd_done` → `err` = 2; 2 RAM writes; no `play_start`.
- **Checksum abort:** valid 4-sample payload followed by `cmd_abort` → `err` = 3; `cfg_rate` keeps its previous value.
- **DDS takeover:** during playback, pulse `dds_cmd` → `custom_active` = 0 and `play_en` = 0 the next cycle. A following upload with ctrl 0x00 commits `cfg_*` but leaves `play_en` = 0.
- **Restart and reset:** `cmd_start` mid-DATA restarts at HDR and the new frame commits correctly. `rst` pulsed mid-upload clears all outputs asynchronously.
